// File: rtl/mem_data_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states, default depth.
package mem_data_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int DEFAULT_DEPTH_BYTES = 256;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_data_align.sv
// Combinational lane steering: store byte-enables and replicated data, load extraction
// with sign/zero extension, and alignment checking.
module mem_data_align
    import mem_data_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_lane_we,
    output logic [31:0] o_lane_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_rword >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_lane_we    = 4'b0000;
        o_lane_wdata = 32'h0000_0000;
        o_load_data  = 32'h0000_0000;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_B: begin
                o_lane_we    = 4'b0001 << i_addr_lo;
                o_lane_wdata = {4{i_wdata[7:0]}};
                o_load_data  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            SZ_H: begin
                o_misaligned = i_addr_lo[0];
                o_lane_we    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_lane_wdata = {2{i_wdata[15:0]}};
                o_load_data  = {{16{w_half[15] & ~i_unsigned}}, w_half};
            end
            SZ_W: begin
                o_misaligned = (i_addr_lo != 2'b00);
                o_lane_we    = 4'b1111;
                o_lane_wdata = i_wdata;
                o_load_data  = i_rword;
            end
            // The illegal size encoding is folded into the misalignment flag.
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_data_sized.sv
// Byte-addressable little-endian data memory with sized loads/stores, registered
// responses, fault reporting and a post-reset clear sequence.
module mem_data_sized
    import mem_data_pkg::*;
#(
    parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_enable,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ready,
    output logic              o_rvalid,
    output logic [31:0]       o_rdata,
    output logic              o_fault
);

    localparam int                WORDS    = DEPTH_BYTES / 4;
    localparam int                IDX_W    = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    logic [31:0]      r_mem [WORDS];
    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_nxt;
    logic             w_ready;

    logic             r_rvalid;
    logic             r_fault;
    logic [31:0]      r_rdata;

    logic [IDX_W-1:0] w_idx;
    logic             w_out_of_range;
    logic [31:0]      w_rword;
    logic [3:0]       w_lane_we;
    logic [31:0]      w_lane_wdata;
    logic [31:0]      w_load_data;
    logic             w_misaligned;
    logic             w_fault;
    logic             w_accept;

    // Handshake: a request transfers on an enabled rising edge where i_req and o_ready
    // are both high; exactly one o_rvalid strobe answers it after that same edge.
    assign w_accept = i_req & w_ready & i_clk_enable;

    assign w_idx          = i_addr[IDX_W+1:2];
    assign w_out_of_range = (i_addr >= DEPTH_A);
    assign w_rword        = w_out_of_range ? 32'h0000_0000 : r_mem[w_idx];
    assign w_fault        = w_misaligned | w_out_of_range;

    mem_data_align u_align (
        .i_size       (i_size),
        .i_addr_lo    (i_addr[1:0]),
        .i_unsigned   (i_unsigned),
        .i_wdata      (i_wdata),
        .i_rword      (w_rword),
        .o_lane_we    (w_lane_we),
        .o_lane_wdata (w_lane_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else if (i_clk_enable) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end
            end
            ST_READY: w_ready = 1'b1;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // The array has no reset; the CLEAR sweep is what zeroes it.
    always_ff @(posedge i_clk) begin
        if (i_clk_enable) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_cnt] <= 32'h0000_0000;
            end else if (w_accept && i_we && !w_fault) begin
                for (int n = 0; n < 4; n++) begin
                    if (w_lane_we[n]) begin
                        r_mem[w_idx][8*n +: 8] <= w_lane_wdata[8*n +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0000_0000;
            r_fault  <= 1'b0;
        end else if (i_clk_enable) begin
            r_rvalid <= w_accept;
            r_fault  <= w_accept & w_fault;
            r_rdata  <= (w_accept && !i_we && !w_fault) ? w_load_data : 32'h0000_0000;
        end
    end

    assign o_ready  = w_ready;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_fault  = r_fault;

endmodule

// File: tb/tb_mem_data_sized.sv
// Self-checking bench for mem_data_sized: byte-array reference model with per-cycle
// comparison, directed literal cases, stall and reset scenarios, random traffic.
module tb_mem_data_sized;

    localparam int DEPTH = 64;
    localparam int WORDS = 16;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        clk_en = 1'b1;
    logic        req    = 1'b0;
    logic        we     = 1'b0;
    logic [1:0]  size   = 2'b00;
    logic        uns    = 1'b0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic        ready;
    logic        rvalid;
    logic        fault;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_data_sized #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (32)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_enable (clk_en),
        .i_req        (req),
        .i_we         (we),
        .i_size       (size),
        .i_unsigned   (uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_ready      (ready),
        .o_rvalid     (rvalid),
        .o_rdata      (rdata),
        .o_fault      (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_mem [DEPTH];
    int          m_edges;
    logic        e_rvalid;
    logic [32:0] exp_q [$];
    logic [32:0] last;
    int          nb;
    logic        bad;
    logic [31:0] v;
    logic        e_ready;

    assign e_ready = (m_edges >= WORDS);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges  = 0;
            e_rvalid = 1'b0;
            exp_q.delete();
            foreach (m_mem[i]) m_mem[i] = 8'h00;
        end else if (clk_en) begin
            if (m_edges >= WORDS && req) begin
                nb  = 1 << size;
                bad = (size == 2'b11) || ((addr % nb) != 0) || (addr >= DEPTH);
                v   = 32'h0;
                if (!bad) begin
                    if (we) begin
                        for (int k = 0; k < nb; k++) m_mem[addr + k] = wdata[8*k +: 8];
                    end else begin
                        for (int k = 0; k < nb; k++) v = v | (32'(m_mem[addr + k]) << (8 * k));
                        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
                    end
                end
                exp_q.push_back({bad, v});
                e_rvalid = 1'b1;
            end else begin
                e_rvalid = 1'b0;
            end
            if (m_edges < WORDS) m_edges++;
        end
    end

    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(e_ready));
        chk("rvalid", 32'(rvalid), 32'(e_rvalid));
        if (e_rvalid) begin
            if (exp_q.size() > 0) last = exp_q.pop_front();
            chk("rdata", rdata, last[31:0]);
            chk("fault", 32'(fault), 32'(last[32]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic f);
        @(negedge clk);
        #2;
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        rd  = rdata;
        f   = fault;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ready) break;
        end
    endtask

    logic [31:0] rd;
    logic        f;
    logic [31:0] held;
    int          cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_ready(cnt);
        chk("clear_edges", 32'(cnt), 32'd16);

        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, f);
        chk("lw10", rd, 32'h0);
        chk("lw10_fault", 32'(f), 32'd0);

        access(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, rd, f);
        access(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, f);
        chk("lb21", rd, 32'hFFFFFFBE);
        access(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, rd, f);
        chk("lbu23", rd, 32'h000000DE);
        access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, f);
        chk("lh22", rd, 32'hFFFFDEAD);
        access(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, f);
        chk("lhu20", rd, 32'h0000BEEF);

        access(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055, rd, f);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, f);
        chk("lw20_sb", rd, 32'hDEAD55EF);
        access(1'b1, 2'b01, 1'b0, 32'h20, 32'h00001234, rd, f);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, f);
        chk("lw20_sh", rd, 32'hDEAD1234);

        access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, f);
        chk("lw22_fault", 32'(f), 32'd1);
        chk("lw22_rdata", rd, 32'h0);
        access(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF, rd, f);
        chk("sh21_fault", 32'(f), 32'd1);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, f);
        chk("lw20_after_fault", rd, 32'hDEAD1234);
        access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, f);
        chk("lw40_fault", 32'(f), 32'd1);
        access(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, f);
        chk("size11_fault", 32'(f), 32'd1);

        access(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, rd, f);
        access(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, rd, f);

        // Stall: accept LW 0x20, then hold clk_en low with a second request pending
        @(negedge clk);
        #2;
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20;
        @(posedge clk);
        #1;
        held = rdata;
        chk("stall_first", held, 32'hDEAD1234);
        clk_en = 1'b0;
        addr   = 32'h24;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_rvalid", 32'(rvalid), 32'd1);
            chk("stall_rdata", rdata, held);
        end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("stall_second", rdata, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        chk("stall_single_accept", 32'(rvalid), 32'd0);

        // Reset during a pending response, then mid-CLEAR
        access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, f);
        chk("lw30", rd, 32'h11223344);
        #1 rst = 1'b1;
        #1;
        chk("rst_pending_rvalid", 32'(rvalid), 32'd0);
        chk("rst_pending_rdata", rdata, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_midclear_ready", 32'(ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_ready(cnt);
        chk("reclear_edges", 32'(cnt), 32'd16);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, f);
        chk("lw20_cleared", rd, 32'h0);
        access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, f);
        chk("lw30_cleared", rd, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #2;
            clk_en = ($urandom_range(0, 9) != 0);
            req    = ($urandom_range(0, 3) != 0);
            we     = 1'($urandom_range(0, 1));
            size   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            uns    = 1'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 300) : $urandom_range(0, 63);
            wdata  = $urandom;
        end
        @(negedge clk);
        #2;
        req    = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_data_sized.md
# mem_data_sized

Parametrised, byte-addressable, little-endian data memory for the pipeline's MEM stage. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Reads are registered with one-cycle latency. Misaligned and out-of-range accesses are reported as faults. After every reset, a clear state machine zeroes the whole array before the first access is accepted.

## Interface
Parameters:
- DEPTH_BYTES, 256, memory size in bytes; multiple of 4, at least 8.
- ADDR_W, 32, address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_clk_enable  in  1  global stall; when low, all state and outputs hold.
- i_req  in  1  access request.
- i_we  in  1  1 = store, 0 = load.
- i_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_ready  out  1  high when a request can be accepted.
- o_rvalid  out  1  one-cycle response strobe, for loads and stores.
- o_rdata  out  32  load result; 0 for stores and faults.
- o_fault  out  1  response is a fault; qualified by o_rvalid.

## Operation
Storage and states:
- Storage is WORDS = DEPTH_BYTES/4 words of 32 bits, each with four byte lanes. Lane n holds byte address 4*w+n.
- States are CLEAR and READY. Reset forces CLEAR with the clear counter at 0.
- CLEAR: each enabled edge writes 0 to word[counter] and increments the counter. The edge that clears word WORDS-1 moves the FSM to READY. In CLEAR, o_ready = 0 and i_req is ignored.
- READY: o_ready = 1. An access is accepted on an edge where i_req, o_ready and i_clk_enable are all high.

Fault check:
- A request faults if any of these holds: i_size = 11; half access with i_addr[0] = 1; word access with i_addr[1:0] != 00; i_addr >= DEPTH_BYTES, compared at full ADDR_W.
- A faulting request writes nothing and returns o_rdata = 0 with o_fault = 1.

Stores:
- Byte: writes i_wdata[7:0] to lane i_addr[1:0].
- Half: writes i_wdata[15:0] to lanes {i_addr[1],0} and {i_addr[1],1}.
- Word: writes all four lanes.
- Other lanes are unchanged.

Loads:
- The selected byte or half is extracted from the addressed word and shifted to bit 0.
- Bits above it are filled with zeros when i_unsigned = 1, otherwise with its top bit. For a word load, i_unsigned is ignored.

## Timing
- Reset values: o_ready = 0, o_rvalid = 0, o_rdata = 0, o_fault = 0, state = CLEAR, counter = 0.
- Memory contents are not reset directly; they are cleared by CLEAR.
- o_ready rises after exactly WORDS enabled edges following reset release.
- Latency: for a request accepted at edge N, o_rvalid, o_rdata and o_fault are valid after edge N.
- o_rvalid drops after the next enabled edge unless a new request is accepted at that edge. Back-to-back requests give o_rvalid high every cycle.
- Store commit happens at the accepting edge. A load accepted on the following edge returns the new data. There is no same-cycle load/store conflict, because there is only one port.
- i_clk_enable low: the FSM, counter, memory and all outputs hold. A pending o_rvalid stays high until the next enabled edge, and no request is accepted.
- Reset asserted at any time, including mid-CLEAR or during a pending response: all outputs drop immediately and CLEAR restarts from word 0.

## Structure
- Shared package mem_data_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W;
  - the state enum {ST_CLEAR, ST_READY};
  - the default DEPTH_BYTES.
- One sub-module, mem_data_align, is purely combinational. Its inputs are size, address low bits, unsigned flag, write data and read word. Its outputs are lane write-enables, lane-aligned write data, the extended load value and a misalignment flag.
- The top level contains the array, the FSM and counter, the range check and the response registers.

## Test plan
Run with DEPTH_BYTES = 64, so WORDS = 16.
- Reset release -> o_ready low for 16 enabled edges, then high. LW 0x10 -> o_rdata 0x00000000, o_fault 0.
- SW 0x20 with data 0xDEADBEEF, then:
  - LB 0x21 -> 0xFFFFFFBE;
  - LBU 0x23 -> 0x000000DE;
  - LH 0x22 -> 0xFFFFDEAD;
  - LHU 0x20 -> 0x0000BEEF.
- After the above, SB 0x21 with data 0x00000055, then LW 0x20 -> 0xDEAD55EF. The next SH 0x20 with data 0x1234 followed by LW 0x20 gives 0xDEAD1234.
- Fault cases:
  - LW 0x22 -> o_fault 1, o_rdata 0.
  - SH 0x21 -> o_fault 1; a following LW 0x20 is unchanged.
  - LW 0x40 -> o_fault 1.
  - i_size = 11 -> o_fault 1.
- Accept an LW, then hold i_clk_enable low for 3 cycles with i_req high -> o_rvalid and o_rdata held. The second request is accepted only on the first enabled edge.
- Assert i_rst after 5 words are cleared -> o_ready stays 0. After release, o_ready takes a full 16 enabled edges to rise, and previously stored words read 0.
